rom_load_sequencer: RTL and testbench

- Avalon-MM slave that sequences NIOS II game-image loads into the shared cartridge PRG/CHR memory port.
- Buffers address/data pairs in a FIFO and auto-increments the write address.
- Holds the NES core in reset while loading.
- Arbitrates the single memory port so NES read requests (NES_REQ) always win over pending load writes.

---
 rtl/rom_load_sequencer.sv | 161 ++++++++++++++++
 tb/tb_rom_load_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_load_sequencer.sv
// Avalon-MM loader that queues address/data bytes and writes them into the shared cartridge
// memory port whenever the NES core is not using it, holding the core in reset meanwhile.
module rom_load_sequencer #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [1:0]        AVL_ADDR,
    input  logic              AVL_CS,
    input  logic              AVL_READ,
    input  logic              AVL_WRITE,
    input  logic [31:0]       AVL_WRITEDATA,
    output logic [31:0]       AVL_READDATA,
    output logic              AVL_WAITREQ,
    input  logic              NES_REQ,
    output logic [ADDR_W-1:0] ROM_ADDR,
    output logic [7:0]        TO_ROM,
    output logic              WRITE_ROM,
    output logic              NES_HOLD,
    output logic              LOAD_DONE
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned ENT_W = ADDR_W + 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLoading = 2'd1,
        StDrain   = 2'd2,
        StDone    = 2'd3
    } state_e;

    state_e            state;
    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    fill;
    logic [ADDR_W-1:0] next_addr;
    logic [16:0]       count;
    logic              err;

    logic              fifo_empty;
    logic              fifo_full;
    logic              busy;
    logic              wr_ctrl;
    logic              wr_base;
    logic              wr_data;
    logic              data_push;
    logic              data_err;
    logic              pop;
    logic [ENT_W-1:0]  head;
    logic [31:0]       rd_val;

    logic              unused_wdata;
    assign unused_wdata = ^AVL_WRITEDATA[31:16];

    always_comb begin
        fifo_empty = (fill == '0);
        fifo_full  = (fill == (PTR_W+1)'(FIFO_DEPTH));
        busy       = (state != StIdle);
        wr_ctrl    = AVL_CS && AVL_WRITE && (AVL_ADDR == 2'd0);
        wr_base    = AVL_CS && AVL_WRITE && (AVL_ADDR == 2'd1);
        wr_data    = AVL_CS && AVL_WRITE && (AVL_ADDR == 2'd2);
        data_push  = wr_data && (state == StLoading) && !fifo_full;
        data_err   = wr_data && (state != StLoading);
        // NES accesses always win the port; a queued byte simply waits.
        pop        = ((state == StLoading) || (state == StDrain)) && !fifo_empty && !NES_REQ;
        head       = fifo_mem[rd_ptr];
        // Only a DATA write that would be accepted can stall; misplaced ones just flag ERR.
        AVL_WAITREQ = RESET && wr_data && (state == StLoading) && fifo_full;
    end

    always_comb begin
        rd_val = '0;
        case (AVL_ADDR)
            2'd0:    rd_val = {24'd0, 2'b00, state, err, fifo_full, fifo_empty, busy};
            2'd1:    rd_val = 32'(next_addr);
            2'd3:    rd_val = 32'(count);
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (data_push) begin
            fifo_mem[wr_ptr] <= {next_addr, AVL_WRITEDATA[7:0]};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state        <= StIdle;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill         <= '0;
            next_addr    <= '0;
            count        <= '0;
            err          <= 1'b0;
            AVL_READDATA <= '0;
            ROM_ADDR     <= '0;
            TO_ROM       <= '0;
            WRITE_ROM    <= 1'b0;
            NES_HOLD     <= 1'b0;
            LOAD_DONE    <= 1'b0;
        end else begin
            if (data_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)       rd_ptr <= rd_ptr + PTR_W'(1);
            case ({data_push, pop})
                2'b10:   fill <= fill + (PTR_W+1)'(1);
                2'b01:   fill <= fill - (PTR_W+1)'(1);
                default: fill <= fill;
            endcase

            WRITE_ROM <= pop;
            ROM_ADDR  <= pop ? head[ENT_W-1:8] : '0;
            TO_ROM    <= pop ? head[7:0] : '0;
            if (pop && (count != 17'h10000)) count <= count + 17'd1;

            if (wr_base) begin
                next_addr <= AVL_WRITEDATA[ADDR_W-1:0];
            end else if (data_push) begin
                next_addr <= next_addr + ADDR_W'(1);
            end

            if (data_err) begin
                err <= 1'b1;
            end else if (wr_ctrl && AVL_WRITEDATA[1]) begin
                err <= 1'b0;
            end

            AVL_READDATA <= (AVL_CS && AVL_READ) ? rd_val : '0;

            case (state)
                StIdle: begin
                    if (wr_ctrl && AVL_WRITEDATA[0]) begin
                        state    <= StLoading;
                        NES_HOLD <= 1'b1;
                        count    <= '0;
                    end
                end
                StLoading: begin
                    if (wr_ctrl && !AVL_WRITEDATA[0]) state <= StDrain;
                end
                StDrain: begin
                    // WRITE_ROM high means the last popped byte is still on the port.
                    if (fifo_empty && !WRITE_ROM) begin
                        state     <= StDone;
                        NES_HOLD  <= 1'b0;
                        LOAD_DONE <= 1'b1;
                    end
                end
                StDone: begin
                    state     <= StIdle;
                    LOAD_DONE <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Randomised scoreboard bench for rom_load_sequencer: expected memory writes are queued at
// stimulus time and a monitor pops them as WRITE_ROM pulses appear.
module tb_rom_load_sequencer;

    localparam int DEPTH = 8;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [1:0]  AVL_ADDR;
    logic        AVL_CS;
    logic        AVL_READ;
    logic        AVL_WRITE;
    logic [31:0] AVL_WRITEDATA;
    logic [31:0] AVL_READDATA;
    logic        AVL_WAITREQ;
    logic        NES_REQ;
    logic [15:0] ROM_ADDR;
    logic [7:0]  TO_ROM;
    logic        WRITE_ROM;
    logic        NES_HOLD;
    logic        LOAD_DONE;

    rom_load_sequencer #(.FIFO_DEPTH(DEPTH), .ADDR_W(16)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .AVL_ADDR      (AVL_ADDR),
        .AVL_CS        (AVL_CS),
        .AVL_READ      (AVL_READ),
        .AVL_WRITE     (AVL_WRITE),
        .AVL_WRITEDATA (AVL_WRITEDATA),
        .AVL_READDATA  (AVL_READDATA),
        .AVL_WAITREQ   (AVL_WAITREQ),
        .NES_REQ       (NES_REQ),
        .ROM_ADDR      (ROM_ADDR),
        .TO_ROM        (TO_ROM),
        .WRITE_ROM     (WRITE_ROM),
        .NES_HOLD      (NES_HOLD),
        .LOAD_DONE     (LOAD_DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    bit   mon_en = 0;
    bit   prev_nes = 0;

    // Reference model state
    bit          m_loading = 0;
    bit          m_err = 0;
    logic [15:0] m_addr = 0;
    int          m_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            if (WRITE_ROM === 1'b1) begin
                chk("arb_after_nes_idle", 32'(prev_nes), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(ROM_ADDR), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rom_addr", 32'(ROM_ADDR), 32'(e.a));
                    chk("rom_data", 32'(TO_ROM), 32'(e.d));
                end
            end else begin
                chk("idle_bus", {8'd0, ROM_ADDR, TO_ROM}, 32'd0);
            end
            if (LOAD_DONE === 1'b1) begin
                done_cnt++;
                chk("hold_low_at_done", 32'(NES_HOLD), 32'd0);
            end
        end
        prev_nes = NES_REQ;
    end

    task automatic avl_wr(input logic [1:0] a, input logic [31:0] d);
        int n;
        AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = a; AVL_WRITEDATA = d;
        n = 0;
        @(negedge CLK);
        while (AVL_WAITREQ === 1'b1 && n < 500) begin
            if (n == 4) NES_REQ = 0;
            @(negedge CLK);
            n++;
        end
        if (n >= 500) chk("waitreq_timeout", 32'(n), 32'd0);
        case (a)
            2'd0: begin
                if (d[0] && !m_loading) begin
                    m_loading = 1;
                    m_len = 0;
                end else if (!d[0]) begin
                    m_loading = 0;
                end
                if (d[1]) m_err = 0;
            end
            2'd1: m_addr = d[15:0];
            2'd2: begin
                if (m_loading) begin
                    exp_q.push_back('{a: m_addr, d: d[7:0]});
                    m_addr = m_addr + 16'd1;
                    m_len++;
                end else begin
                    m_err = 1;
                end
            end
            default: ;
        endcase
        @(posedge CLK);
        #1;
        AVL_CS = 0; AVL_WRITE = 0; AVL_ADDR = 0;
    endtask

    task automatic avl_rd(input logic [1:0] a, output logic [31:0] v);
        AVL_CS = 1; AVL_READ = 1; AVL_ADDR = a;
        @(posedge CLK);
        #1;
        v = AVL_READDATA;
        AVL_CS = 0; AVL_READ = 0; AVL_ADDR = 0;
    endtask

    function automatic logic [31:0] idle_status();
        return {28'd0, m_err, 1'b0, 1'b1, 1'b0};
    endfunction

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge CLK);
        while (LOAD_DONE !== 1'b1 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk("load_done_seen", 32'(LOAD_DONE), 32'd1);
        @(posedge CLK);
        #1;
    endtask

    task automatic finish_checks(input string tag);
        logic [31:0] v;
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        avl_rd(2'd3, v);
        chk({tag, "_count"}, v, 32'(m_len));
        avl_rd(2'd0, v);
        chk({tag, "_status"}, v, idle_status());
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int d0;
        int bp_base;
        int bp9;
        bit seen;

        RESET = 0; AVL_ADDR = 0; AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0;
        AVL_WRITEDATA = 0; NES_REQ = 0;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1;
        mon_en = 1;

        // Reset state
        chk("rst_outputs", {AVL_READDATA[3:0], AVL_WAITREQ, WRITE_ROM, NES_HOLD, LOAD_DONE}, 32'd0);
        avl_rd(2'd0, v);
        chk("rst_status", v, 32'h02);
        avl_rd(2'd3, v);
        chk("rst_count", v, 32'd0);

        // Basic load
        d0 = done_cnt;
        chk("hold_before_load", 32'(NES_HOLD), 32'd0);
        avl_wr(2'd0, 32'h1);
        chk("hold_after_load", 32'(NES_HOLD), 32'd1);
        avl_wr(2'd1, 32'h8000);
        avl_wr(2'd2, 32'hA9);
        avl_wr(2'd2, 32'h01);
        avl_wr(2'd2, 32'h60);
        chk("hold_during_load", 32'(NES_HOLD), 32'd1);
        avl_wr(2'd0, 32'h0);
        wait_done();
        repeat (3) @(posedge CLK);
        #1;
        chk("basic_one_done", 32'(done_cnt - d0), 32'd1);
        finish_checks("basic");
        chk("basic_len", 32'(m_len), 32'd3);

        // Backpressure
        NES_REQ = 1;
        bp_base = int'($urandom_range(0, 16'hFFF0));
        avl_wr(2'd0, 32'h1);
        avl_wr(2'd1, 32'(bp_base));
        for (int i = 0; i < DEPTH; i++) avl_wr(2'd2, $urandom);
        bp9 = int'($urandom_range(0, 255));
        AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 2'd2; AVL_WRITEDATA = 32'(bp9);
        exp_q.push_back('{a: m_addr, d: 8'(bp9)});
        m_addr = m_addr + 16'd1;
        m_len++;
        repeat (3) begin
            @(negedge CLK);
            chk("bp_waitreq_high", 32'(AVL_WAITREQ), 32'd1);
        end
        @(posedge CLK);
        #1;
        NES_REQ = 0;
        @(posedge CLK);
        @(negedge CLK);
        chk("bp_waitreq_fall", 32'(AVL_WAITREQ), 32'd0);
        @(posedge CLK);
        #1;
        AVL_CS = 0; AVL_WRITE = 0; AVL_ADDR = 0;
        avl_wr(2'd0, 32'h0);
        wait_done();
        finish_checks("bp");

        // Address wrap
        avl_wr(2'd0, 32'h1);
        avl_wr(2'd1, 32'hFFFF);
        avl_wr(2'd2, $urandom);
        avl_wr(2'd2, $urandom);
        avl_wr(2'd0, 32'h0);
        wait_done();
        finish_checks("wrap");
        avl_rd(2'd1, v);
        chk("wrap_base", v, 32'h0001);

        // Error path
        avl_wr(2'd2, 32'h55);
        repeat (4) @(posedge CLK);
        #1;
        avl_rd(2'd0, v);
        chk("err_set", v, 32'h0A);
        avl_rd(2'd2, v);
        chk("data_reads_zero", v, 32'd0);
        avl_wr(2'd0, 32'h2);
        avl_rd(2'd0, v);
        chk("err_clear", v, 32'h02);

        // Interleaved arbitration
        NES_REQ = 1;
        avl_wr(2'd0, 32'h1);
        avl_wr(2'd1, $urandom);
        for (int i = 0; i < 4; i++) avl_wr(2'd2, $urandom);
        avl_wr(2'd0, 32'h1);
        avl_wr(2'd0, 32'h0);
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge CLK);
            if (LOAD_DONE === 1'b1) seen = 1;
            @(posedge CLK);
            #1;
            NES_REQ = ~NES_REQ;
        end
        NES_REQ = 0;
        chk("inter_done", 32'(seen), 32'd1);
        finish_checks("inter");
        chk("inter_len", 32'(m_len), 32'd4);

        // Randomised loads
        for (int k = 0; k < 4; k++) begin
            int len;
            len = int'($urandom_range(1, 12));
            avl_wr(2'd0, 32'h1);
            avl_wr(2'd1, $urandom);
            for (int i = 0; i < len; i++) begin
                NES_REQ = ($urandom_range(0, 2) == 0);
                avl_wr(2'd2, $urandom);
            end
            NES_REQ = 0;
            avl_wr(2'd0, 32'h0);
            wait_done();
            finish_checks("rand");
        end

        // Reset mid-load
        NES_REQ = 1;
        avl_wr(2'd0, 32'h1);
        avl_wr(2'd1, $urandom);
        for (int i = 0; i < 5; i++) avl_wr(2'd2, $urandom);
        RESET = 0;
        @(posedge CLK);
        #1;
        RESET = 1;
        exp_q.delete();
        m_loading = 0; m_err = 0; m_addr = 0; m_len = 0;
        NES_REQ = 0;
        repeat (20) @(posedge CLK);
        #1;
        chk("rst_mid_hold", 32'(NES_HOLD), 32'd0);
        avl_rd(2'd0, v);
        chk("rst_mid_status", v, 32'h02);
        avl_rd(2'd1, v);
        chk("rst_mid_base", v, 32'd0);
        avl_rd(2'd3, v);
        chk("rst_mid_count", v, 32'd0);

        repeat (2) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
